sfifo_flags: RTL and testbench
==============================

SFIFO_FLAGS -- requirements
Module: sfifo_flags

Interface
REQ-001 The block SHALL have parameter BW, default 8, data width in bits.
REQ-002 The block SHALL have parameter LGFLEN, default 4, log2 of depth (depth = 2**LGFLEN).
REQ-003 The block SHALL have parameter AF_LVL, default 14, almost-full threshold (fill >= AF_LVL).
REQ-004 The block SHALL have parameter AE_LVL, default 2, almost-empty threshold (fill <= AE_LVL).
REQ-005 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-006 The block SHALL have port i_clk, input, 1, the sole clock, with all state updated on its rising edge.
REQ-007 The block SHALL have port i_reset, input, 1, synchronous active-high reset.
REQ-008 The block SHALL have port i_wr, input, 1, write request.
REQ-009 The block SHALL have port i_data, input, BW, write data.
REQ-010 The block SHALL have port i_rd, input, 1, read/pop request.
REQ-011 The block SHALL have port i_clr_err, input, 1, clears the sticky error flags.
REQ-012 The block SHALL have port o_data, output, BW, read data.
REQ-013 The block SHALL have port o_fill, output, LGFLEN+1, current occupancy 0..2**LGFLEN.
REQ-014 The block SHALL have ports o_full, o_empty, o_afull and o_aempty, output, 1 each, occupancy flags.
REQ-015 The block SHALL have ports o_overflow and o_underflow, output, 1 each, sticky error flags.

Function
REQ-016 A write SHALL be accepted when i_wr && (!o_full || accepted read in the same cycle), storing i_data at wr_ptr and incrementing wr_ptr.
REQ-017 A read SHALL be accepted when i_rd && !o_empty, incrementing rd_ptr.
REQ-018 Pointers SHALL be LGFLEN+1 bits wide, wrap modulo 2**(LGFLEN+1), and address memory with their low LGFLEN bits.
REQ-019 o_fill SHALL be a register updated each cycle: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-020 Flags SHALL be: o_full = (o_fill == 2**LGFLEN), o_empty = (o_fill == 0), o_afull = (o_fill >= AF_LVL), o_aempty = (o_fill <= AE_LVL); they SHALL be decoded from registered o_fill only.
REQ-021 With simultaneous i_wr and i_rd while full, both SHALL be accepted, o_fill SHALL stay at 2**LGFLEN, and no overflow SHALL be flagged.
REQ-022 With simultaneous i_wr and i_rd while empty, the write SHALL be accepted, the read SHALL be rejected, and underflow SHALL be set.
REQ-023 A rejected write (i_wr && o_full && no accepted read) SHALL set o_overflow, with memory and pointers unchanged.
REQ-024 A rejected read (i_rd && o_empty) SHALL set o_underflow, with o_data unchanged.
REQ-025 o_overflow and o_underflow SHALL hold until i_clr_err=1 or reset; if set and clear occur in the same cycle, set wins.
REQ-026 In default (registered) mode, o_data SHALL update one cycle after an accepted read with the entry at the old rd_ptr, and SHALL hold otherwise.
REQ-027 The AF_LVL and AE_LVL values SHALL satisfy 0 <= AE_LVL < AF_LVL <= 2**LGFLEN, checked at elaboration with an error.

Reset
REQ-028 When i_reset=1 at a clock edge, wr_ptr, rd_ptr and o_fill SHALL become 0, o_empty=1, o_aempty=1, o_full=0, o_afull=0, o_overflow=0, o_underflow=0 and o_data=0.
REQ-029 During a reset cycle, i_wr, i_rd and i_clr_err SHALL be ignored, memory contents need not be cleared, and the FIFO SHALL be empty in the cycle after reset.

Configuration
REQ-030 When macro SFIFO_FWFT_EN is defined, the block SHALL run first-word-fall-through: o_data SHALL show the head entry combinationally whenever !o_empty, an entry SHALL be visible the cycle after it is written, and i_rd SHALL pop it; o_data is don't-care while empty.
REQ-031 When SFIFO_FWFT_EN is undefined, the registered read behaviour of REQ-026 SHALL apply.
REQ-032 All flag, error and pointer behaviour SHALL be identical in both modes.

Structure
REQ-033 Package sfifo_pkg SHALL hold the ptr_t/fill_t width helpers and a localparam function computing depth from LGFLEN.
REQ-034 Storage SHALL be a sub-module sfifo_mem with one write port and one async read port, parameterised on BW and LGFLEN; it SHALL contain no reset.

Verification (BW=8, LGFLEN=4, AF_LVL=14, AE_LVL=2)
REQ-035 Reset, then write 0x01..0x10 on 16 cycles -> o_fill=16, o_full=1, o_afull=1 from fill 14; then 16 reads -> data 0x01..0x10 in order, o_empty=1.
REQ-036 Full FIFO, i_wr with i_rd=0 and data 0xAA -> o_overflow=1, o_fill=16, 0xAA is never read; i_clr_err pulse -> o_overflow=0.
REQ-037 Full FIFO, i_wr=i_rd=1 for 20 cycles -> o_fill stays 16, o_overflow=0, reads return the original 16 entries, then new data in order.
REQ-038 Empty FIFO, i_wr=i_rd=1 with data 0x55 -> o_fill=1, o_underflow=1; next read returns 0x55.
REQ-039 Assert i_reset mid-stream at fill=7 with i_wr=1 -> next cycle o_fill=0, o_empty=1, flags cleared, and the written word is dropped.
REQ-040 With SFIFO_FWFT_EN, write 0x3C to an empty FIFO -> o_data=0x3C in the next cycle with no i_rd; i_rd=1 -> o_empty=1 in the following cycle.

Source files
------------

// File: rtl/sfifo_pkg.sv
// Shared width helpers for the synchronous FIFO with occupancy flags.
package sfifo_pkg;

    localparam int unsigned DEFAULT_LGFLEN = 4;

    // Pointer and fill widths at the default depth.
    typedef logic [DEFAULT_LGFLEN:0] ptr_t;
    typedef logic [DEFAULT_LGFLEN:0] fill_t;

    // Number of entries for a given log2 depth.
    function automatic int unsigned fifo_depth(input int unsigned lgflen);
        return 32'(1) << lgflen;
    endfunction

    // Pointers carry one extra wrap bit above the address bits.
    function automatic int unsigned ptr_width(input int unsigned lgflen);
        return lgflen + 1;
    endfunction

    // Fill must represent 0..depth inclusive.
    function automatic int unsigned fill_width(input int unsigned lgflen);
        return lgflen + 1;
    endfunction

endpackage

// File: rtl/sfifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module sfifo_mem #(
    parameter int unsigned BW     = 8,
    parameter int unsigned LGFLEN = 4
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [LGFLEN-1:0] i_waddr,
    input  logic [BW-1:0]     i_wdata,
    input  logic [LGFLEN-1:0] i_raddr,
    output logic [BW-1:0]     o_rdata
);

    localparam int unsigned DEPTH = 32'(1) << LGFLEN;

    logic [BW-1:0] mem_q [DEPTH];

    // Write port.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    // Asynchronous read port.
    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/sfifo_flags.sv
// Synchronous FIFO with registered fill count, occupancy flags and sticky
// overflow/underflow errors. Define SFIFO_FWFT_EN for first-word-fall-through
// read data; otherwise o_data is registered and updates after each pop.
module sfifo_flags
    import sfifo_pkg::*;
#(
    parameter int unsigned BW     = 8,
    parameter int unsigned LGFLEN = 4,
    parameter int unsigned AF_LVL = 14,
    parameter int unsigned AE_LVL = 2
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_wr,
    input  logic [BW-1:0]       i_data,
    input  logic                i_rd,
    input  logic                i_clr_err,
    output logic [BW-1:0]       o_data,
    output logic [LGFLEN:0]     o_fill,
    output logic                o_full,
    output logic                o_empty,
    output logic                o_afull,
    output logic                o_aempty,
    output logic                o_overflow,
    output logic                o_underflow
);

    localparam int unsigned DEPTH  = fifo_depth(LGFLEN);
    localparam int unsigned PTR_W  = ptr_width(LGFLEN);
    localparam int unsigned FILL_W = fill_width(LGFLEN);

    // Threshold sanity: AE_LVL < AF_LVL <= depth (AE_LVL >= 0 by type).
    if (!((AE_LVL < AF_LVL) && (AF_LVL <= DEPTH))) begin : g_bad_levels
        $error("sfifo_flags: require 0 <= AE_LVL < AF_LVL <= 2**LGFLEN");
    end

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0] fill_q,   fill_d;
    logic              ovf_q,    ovf_d;
    logic              udf_q,    udf_d;
    logic              wr_acc,   rd_acc;
    logic              mem_we;
    logic [BW-1:0]     mem_rdata;

    sfifo_mem #(
        .BW     (BW),
        .LGFLEN (LGFLEN)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (mem_we),
        .i_waddr (wr_ptr_q[LGFLEN-1:0]),
        .i_wdata (i_data),
        .i_raddr (rd_ptr_q[LGFLEN-1:0]),
        .o_rdata (mem_rdata)
    );

    // Flags decoded from the registered fill count only.
    assign o_fill   = fill_q;
    assign o_full   = (fill_q == FILL_W'(DEPTH));
    assign o_empty  = (fill_q == '0);
    assign o_afull  = (fill_q >= FILL_W'(AF_LVL));
    assign o_aempty = (fill_q <= FILL_W'(AE_LVL));
    assign o_overflow  = ovf_q;
    assign o_underflow = udf_q;

    // Accept decisions, pointer/fill next state and sticky error update.
    always_comb begin
        rd_acc   = i_rd && !o_empty;
        wr_acc   = i_wr && (!o_full || rd_acc);
        mem_we   = wr_acc && !i_reset;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;

        if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_W'(1);

        case ({wr_acc, rd_acc})
            2'b10:   fill_d = fill_q + FILL_W'(1);
            2'b01:   fill_d = fill_q - FILL_W'(1);
            default: fill_d = fill_q;
        endcase

        // Set has priority over clear.
        if (i_clr_err) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (i_wr && !wr_acc) ovf_d = 1'b1;
        if (i_rd && o_empty) udf_d = 1'b1;
    end

    // Pointer, fill and error registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

`ifdef SFIFO_FWFT_EN
    // Head entry shown directly; meaningless while empty.
    assign o_data = mem_rdata;
`else
    logic [BW-1:0] data_q, data_d;

    // Capture the head entry on an accepted pop, hold otherwise.
    always_comb begin
        data_d = data_q;
        if (rd_acc) data_d = mem_rdata;
    end

    // Registered read data.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign o_data = data_q;
`endif

endmodule

// File: tb/tb_sfifo_flags.sv
// Randomized plus directed bench for sfifo_flags against a queue-based model.
module tb_sfifo_flags;

    localparam int unsigned DEPTH = 16;

    logic       clk;
    logic       i_reset, i_wr, i_rd, i_clr_err;
    logic [7:0] i_data;
    logic [7:0] o_data;
    logic [4:0] o_fill;
    logic       o_full, o_empty, o_afull, o_aempty, o_overflow, o_underflow;

    sfifo_flags #(
        .BW(8), .LGFLEN(4), .AF_LVL(14), .AE_LVL(2)
    ) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_wr        (i_wr),
        .i_data      (i_data),
        .i_rd        (i_rd),
        .i_clr_err   (i_clr_err),
        .o_data      (o_data),
        .o_fill      (o_fill),
        .o_full      (o_full),
        .o_empty     (o_empty),
        .o_afull     (o_afull),
        .o_aempty    (o_aempty),
        .o_overflow  (o_overflow),
        .o_underflow (o_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    logic [7:0] mq[$];
    logic [7:0] m_data = 8'h00;
    logic       m_ovf  = 1'b0;
    logic       m_udf  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        int sz;
        sz = mq.size();
        check("fill",      32'(o_fill),      32'(sz));
        check("full",      32'(o_full),      32'(sz == DEPTH));
        check("empty",     32'(o_empty),     32'(sz == 0));
        check("afull",     32'(o_afull),     32'(sz >= 14));
        check("aempty",    32'(o_aempty),    32'(sz <= 2));
        check("overflow",  32'(o_overflow),  32'(m_ovf));
        check("underflow", 32'(o_underflow), 32'(m_udf));
`ifdef SFIFO_FWFT_EN
        if (sz > 0) check("data", 32'(o_data), 32'(mq[0]));
`else
        check("data",      32'(o_data),      32'(m_data));
`endif
    endtask

    // One clock: apply inputs, advance the model at the edge, then compare.
    task automatic step(input logic w, input logic [7:0] d, input logic r,
                        input logic c, input logic rs);
        bit was_full, was_empty, rd_ok, wr_ok, set_o, set_u;
        i_wr = w; i_data = d; i_rd = r; i_clr_err = c; i_reset = rs;
        @(posedge clk);
        if (rs) begin
            mq.delete();
            m_data = 8'h00;
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
        end else begin
            was_full  = (mq.size() == DEPTH);
            was_empty = (mq.size() == 0);
            rd_ok = r && !was_empty;
            wr_ok = w && (!was_full || rd_ok);
            if (rd_ok) m_data = mq.pop_front();
            if (wr_ok) mq.push_back(d);
            set_o = w && !wr_ok;
            set_u = r && was_empty;
            m_ovf = set_o ? 1'b1 : (c ? 1'b0 : m_ovf);
            m_udf = set_u ? 1'b1 : (c ? 1'b0 : m_udf);
        end
        #1;
        check_all();
    endtask

    initial begin
        i_reset = 1'b1; i_wr = 1'b0; i_rd = 1'b0; i_clr_err = 1'b0; i_data = 8'h00;

        // Reset state.
        step(0, 8'h00, 0, 0, 1);
        step(1, 8'hFF, 1, 1, 1);

        // Fill with 0x01..0x10, then drain in order.
        for (int i = 1; i <= 16; i++) step(1, 8'(i), 0, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0, 0);

        // Overflow on full, data 0xAA discarded, then clear.
        for (int i = 1; i <= 16; i++) step(1, 8'(8'h20 + i), 0, 0, 0);
        step(1, 8'hAA, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        step(0, 8'h00, 0, 1, 0);

        // Simultaneous write/read while full for 20 cycles, then drain.
        for (int i = 0; i < 20; i++) step(1, 8'(8'h80 + i), 1, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0, 0);

        // Simultaneous write/read while empty: write taken, underflow set.
        step(1, 8'h55, 1, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        // Underflow re-set in the same cycle as clear: set wins.
        step(0, 8'h00, 1, 1, 0);
        step(0, 8'h00, 0, 1, 0);

        // Reset mid-stream at fill 7 with a write pending.
        for (int i = 0; i < 7; i++) step(1, 8'(8'h40 + i), 0, 0, 0);
        step(1, 8'h99, 0, 0, 1);
        step(0, 8'h00, 0, 0, 0);

        // Randomized segments with varied write/read pressure.
        for (int s = 0; s < 10; s++) begin
            int pw, pr;
            pw = $urandom_range(10, 90);
            pr = $urandom_range(10, 90);
            for (int k = 0; k < 200; k++) begin
                step($urandom_range(99, 0) < pw,
                     8'($urandom),
                     $urandom_range(99, 0) < pr,
                     $urandom_range(99, 0) < 5,
                     $urandom_range(999, 0) < 4);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
